// File: rtl/param_decoder.sv
// param_decoder: registered binary-to-one-hot decoder with enable.
// An IN_WIDTH-bit index selects one of OUT_WIDTH lines. The one-hot result,
// valid and range_err appear one clock after the inputs are sampled.
module param_decoder #(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in,
    input  logic                 enable,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 valid,
    output logic                 range_err
);

    // Reject configurations where the output lines cannot all be addressed
    // or where the index has no bits at all.
    if (IN_WIDTH < 1 || OUT_WIDTH < 1 || OUT_WIDTH > (1 << IN_WIDTH)) begin : g_bad_cfg
        $error("param_decoder: need IN_WIDTH>=1 and 1<=OUT_WIDTH<=2**IN_WIDTH");
    end

    logic [OUT_WIDTH-1:0] hit;
    logic [OUT_WIDTH-1:0] out_d,       out_q;
    logic                 valid_d,     valid_q;
    logic                 range_err_d, range_err_q;

    // One comparator per output line. Gating with enable first keeps an X/Z
    // index from leaking into the result while the decoder is disabled.
    for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_line
        localparam logic [IN_WIDTH-1:0] IDX = IN_WIDTH'(i);
        assign hit[i] = enable && (in == IDX);
    end

    // Next-state: an enabled index with no matching line is out of range.
    always_comb begin
        out_d       = '0;
        valid_d     = 1'b0;
        range_err_d = 1'b0;
        if (enable) begin
            out_d       = hit;
            valid_d     = |hit;
            range_err_d = ~(|hit);
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            valid_q     <= valid_d;
            range_err_q <= range_err_d;
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_param_decoder.sv
// tb_param_decoder: directed checks of the default 2-to-4 decoder, the
// out-of-range path on a 3-to-5 decoder, and a random run on a 4-to-16.
module tb_param_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default 2-to-4 instance
    logic [1:0]  in_a = '0;
    logic        en_a = 1'b0;
    logic [3:0]  out_a;
    logic        vld_a, err_a;

    // 3-to-5 instance with unreachable indices 5..7
    logic [2:0]  in_b = '0;
    logic        en_b = 1'b0;
    logic [4:0]  out_b;
    logic        vld_b, err_b;

    // 4-to-16 instance for the random run
    logic [3:0]  in_c = '0;
    logic        en_c = 1'b0;
    logic [15:0] out_c;
    logic        vld_c, err_c;

    param_decoder #(.IN_WIDTH(2), .OUT_WIDTH(4)) u_dec_a (
        .clk(clk), .rst_n(rst_n), .in(in_a), .enable(en_a),
        .out(out_a), .valid(vld_a), .range_err(err_a));

    param_decoder #(.IN_WIDTH(3), .OUT_WIDTH(5)) u_dec_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .enable(en_b),
        .out(out_b), .valid(vld_b), .range_err(err_b));

    param_decoder #(.IN_WIDTH(4), .OUT_WIDTH(16)) u_dec_c (
        .clk(clk), .rst_n(rst_n), .in(in_c), .enable(en_c),
        .out(out_c), .valid(vld_c), .range_err(err_c));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_c;

        // Reset held with a live decode request on the inputs.
        rst_n = 1'b0; en_a = 1'b1; in_a = 2'b10;
        tick(); tick();
        chk("rst_out_a", 32'(out_a), 32'h0);
        chk("rst_vld_a", 32'(vld_a), 32'h0);
        chk("rst_err_a", 32'(err_a), 32'h0);
        chk("rst_out_b", 32'(out_b), 32'h0);
        chk("rst_out_c", 32'(out_c), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rel_out_a", 32'(out_a), 32'b0100);
        chk("rel_vld_a", 32'(vld_a), 32'h1);

        // Sweep every index with one-cycle latency.
        for (int i = 0; i < 4; i++) begin
            in_a = 2'(i);
            tick();
            chk($sformatf("sweep_out_%0d", i), 32'(out_a), 32'(1 << i));
            chk($sformatf("sweep_vld_%0d", i), 32'(vld_a), 32'h1);
            chk($sformatf("sweep_err_%0d", i), 32'(err_a), 32'h0);
        end

        // Disable ignores the index, including an unknown one.
        en_a = 1'b0; in_a = 2'b11;
        tick();
        chk("dis_out", 32'(out_a), 32'h0);
        chk("dis_vld", 32'(vld_a), 32'h0);
        in_a = 2'bxx;
        tick();
        chk("dis_x_out", 32'(out_a), 32'h0);
        chk("dis_x_vld", 32'(vld_a), 32'h0);
        chk("dis_x_err", 32'(err_a), 32'h0);
        en_a = 1'b1; in_a = 2'b11;
        tick();
        chk("reen_out", 32'(out_a), 32'b1000);

        // Asynchronous clear in the middle of a cycle.
        in_a = 2'b01;
        tick();
        chk("pre_arst_out", 32'(out_a), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out_a), 32'h0);
        chk("arst_vld", 32'(vld_a), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_arst_out", 32'(out_a), 32'b0010);
        chk("post_arst_vld", 32'(vld_a), 32'h1);
        en_a = 1'b0;

        // Out-of-range on the 3-to-5 decoder; 4 is the top legal index.
        en_b = 1'b1; in_b = 3'd4;
        tick();
        chk("b4_out", 32'(out_b), 32'b10000);
        chk("b4_vld", 32'(vld_b), 32'h1);
        chk("b4_err", 32'(err_b), 32'h0);
        in_b = 3'd6;
        tick();
        chk("b6_out", 32'(out_b), 32'h0);
        chk("b6_vld", 32'(vld_b), 32'h0);
        chk("b6_err", 32'(err_b), 32'h1);
        in_b = 3'd5;
        tick();
        chk("b5_err", 32'(err_b), 32'h1);
        chk("b5_out", 32'(out_b), 32'h0);
        in_b = 3'd0;
        tick();
        chk("b0_out", 32'(out_b), 32'b00001);
        chk("b0_err", 32'(err_b), 32'h0);
        en_b = 1'b0; in_b = 3'd7;
        tick();
        chk("b_dis_err", 32'(err_b), 32'h0);

        // Random run on the full 4-to-16 decoder.
        for (int n = 0; n < 1000; n++) begin
            en_c = 1'($urandom_range(0, 3) != 0);
            in_c = 4'($urandom_range(0, 15));
            exp_c = en_c ? (16'h1 << in_c) : 16'h0;
            tick();
            chk("rnd_out", 32'(out_c), 32'(exp_c));
            chk("rnd_onehot", 32'($onehot0(out_c)), 32'h1);
            chk("rnd_vld", 32'(vld_c), 32'(|out_c));
            chk("rnd_err", 32'(err_c), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
